// File: rtl/uart_pkg.sv
// uart_pkg: UART register map, STATUS bit positions and scheduler state encoding.
package uart_pkg;
   localparam logic [7:0] OFF_CTRL   = 8'h00;
   localparam logic [7:0] OFF_STATUS = 8'h04;
   localparam logic [7:0] OFF_BAUD   = 8'h08;
   localparam logic [7:0] OFF_TXDATA = 8'h0C;
   localparam logic [7:0] OFF_RXDATA = 8'h10;
   localparam int TX_BUSY = 0;
   localparam int RX_OVER = 1;
   typedef enum logic [4:0] {
      S_INIT_BAUD = 5'b00001,
      S_INIT_CTRL = 5'b00010,
      S_IDLE      = 5'b00100,
      S_POLL      = 5'b01000,
      S_WRITE     = 5'b10000
   } state_t;
   // Offsets land in the low byte of the base address only.
   function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [7:0] off);
      return {base[31:8], base[7:0] + off};
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrapping pointers and an occupancy count.
module sync_fifo #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [W-1:0]           data_i,
   output logic [W-1:0]           data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] level_o
);
   localparam int unsigned AW = $clog2(DEPTH);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q;
   logic          do_push, do_pop;
   always_comb begin
      full_o  = cnt_q == (AW+1)'(DEPTH);
      empty_o = cnt_q == '0;
      do_push = push_i & ~full_o;
      do_pop  = pop_i & ~empty_o;
      data_o  = mem_q[rd_q];
      level_o = cnt_q;
   end
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin merge of two byte sources into a FIFO, drained to the
// UART by an init/poll/write bus master.
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
   parameter logic [31:0] BAUD_DIV   = 32'h1B8,
   parameter logic [31:0] CTRL_VAL   = 32'h1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic                        s0_valid,
   input  logic [7:0]                  s0_data,
   output logic                        s0_ready,
   input  logic                        s1_valid,
   input  logic [7:0]                  s1_data,
   output logic                        s1_ready,
   output logic                        req_o,
   output logic                        we_o,
   output logic [31:0]                 addr_o,
   output logic [31:0]                 data_o,
   input  logic [31:0]                 data_i,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] level
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   state_t     state_q, state_d;
   logic       rr_q, rr_d, grant0, grant1, full, empty, push, pop, drained;
   logic       unused_status;
   logic [7:0] push_data, head;

   sync_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .rst(rst), .push_i(push), .pop_i(pop), .data_i(push_data),
      .data_o(head), .full_o(full), .empty_o(empty), .level_o(level)
   );

   always_comb begin
      grant0        = s0_valid & (~s1_valid | rr_q);
      grant1        = s1_valid & (~s0_valid | ~rr_q);
      s0_ready      = grant0 & ~full;
      s1_ready      = grant1 & ~full;
      push          = (s0_valid & s0_ready) | (s1_valid & s1_ready);
      push_data     = grant0 ? s0_data : s1_data;
      rr_d          = push ? grant1 : rr_q;
      pop           = rst & (state_q == S_WRITE);
      drained       = (level == LW'(1)) & ~push;
      busy          = (state_q != S_IDLE) | ~empty;
      unused_status = ^data_i[31:1];
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INIT_BAUD: state_d = S_INIT_CTRL;
         S_INIT_CTRL: state_d = S_IDLE;
         S_IDLE:      state_d = (en & ~empty) ? S_POLL : S_IDLE;
         S_POLL:      state_d = ~en ? S_IDLE : (data_i[TX_BUSY] ? S_POLL : S_WRITE);
         S_WRITE:     state_d = (en & ~drained) ? S_POLL : S_IDLE;
         default:     state_d = S_INIT_BAUD;
      endcase
   end

   // Bus drive is decoded from the current state so a read samples data_i in its own cycle.
   always_comb begin
      req_o  = rst & (state_q != S_IDLE);
      we_o   = req_o & (state_q != S_POLL);
      addr_o = ~req_o ? '0 :
               state_q == S_INIT_BAUD ? reg_addr(BASE_ADDR, OFF_BAUD) :
               state_q == S_INIT_CTRL ? reg_addr(BASE_ADDR, OFF_CTRL) :
               state_q == S_POLL      ? reg_addr(BASE_ADDR, OFF_STATUS) :
                                        reg_addr(BASE_ADDR, OFF_TXDATA);
      data_o = ~we_o ? '0 :
               state_q == S_INIT_BAUD ? BAUD_DIV :
               state_q == S_INIT_CTRL ? CTRL_VAL : {24'h0, head};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_INIT_BAUD;
         rr_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
      end
   end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed corners plus random traffic against a queue-level model,
// with a small UART stand-in answering STATUS reads.
module tb_uart_tx_sched;
   localparam logic [31:0] BASE = 32'h3000_0000;
   typedef enum {A_BAUD, A_CTRL, A_IDLE, A_POLL, A_WRITE} act_t;

   logic        clk = 1'b0, rst = 1'b0, en = 1'b0;
   logic        s0_valid = 1'b0, s1_valid = 1'b0, s0_ready, s1_ready;
   logic [7:0]  s0_data = '0, s1_data = '0;
   logic        req_o, we_o, busy;
   logic [31:0] addr_o, data_o, data_i;
   logic [4:0]  level;
   int          n_chk = 0, n_pass = 0;
   int          frame = 3, busy_cnt = 0;
   bit          force_busy = 1'b0, prev_txw = 1'b0, m_was_rst = 1'b0, m_rr = 1'b1;
   logic [7:0]  wr_log[$];
   logic [7:0]  m_q[$];
   act_t        m_act = A_BAUD;
   logic [7:0]  ct_exp [6] = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2};

   uart_tx_sched dut (
      .clk(clk), .rst(rst), .en(en),
      .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
      .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
      .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .data_o(data_o), .data_i(data_i),
      .busy(busy), .level(level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
   endtask

   // UART stand-in: TX busy for `frame` non-write cycles after each TXDATA write.
   assign data_i = {31'b0, force_busy | (busy_cnt != 0)};
   always @(posedge clk) begin
      if (!rst) busy_cnt <= 0;
      else if (req_o && we_o && addr_o == BASE + 32'h0C) begin
         busy_cnt <= frame;
         wr_log.push_back(data_o[7:0]);
      end else if (!we_o && busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end

   always @(negedge clk) begin : model
      bit full, r0, r1;
      int n;
      if (!rst) begin
         chk("rst_req", req_o, 0);
         chk("rst_we", we_o, 0);
         chk("rst_addr", addr_o, 0);
         chk("rst_data", data_o, 0);
         if (m_was_rst) chk("rst_level", level, 0);
         m_was_rst = 1'b1;
         m_q.delete();
         m_rr = 1'b1;
         m_act = A_BAUD;
         prev_txw = 1'b0;
      end else begin
         m_was_rst = 1'b0;
         n = m_q.size();
         full = n == 16;
         r0 = s0_valid && (!s1_valid || m_rr) && !full;
         r1 = s1_valid && (!s0_valid || !m_rr) && !full;
         chk("s0_ready", s0_ready, r0);
         chk("s1_ready", s1_ready, r1);
         chk("level", level, n);
         chk("busy", busy, m_act != A_IDLE || n != 0);
         if (prev_txw) chk("no_b2b", we_o, 0);
         prev_txw = req_o && we_o && addr_o == BASE + 32'h0C;
         chk("req", req_o, m_act != A_IDLE);
         chk("we", we_o, m_act inside {A_BAUD, A_CTRL, A_WRITE});
         case (m_act)
            A_BAUD: begin
               chk("baud_addr", addr_o, BASE + 32'h08);
               chk("baud_data", data_o, 32'h1B8);
            end
            A_CTRL: begin
               chk("ctrl_addr", addr_o, BASE);
               chk("ctrl_data", data_o, 32'h1);
            end
            A_POLL: chk("poll_addr", addr_o, BASE + 32'h04);
            A_WRITE: begin
               chk("tx_addr", addr_o, BASE + 32'h0C);
               chk("tx_data", data_o, n > 0 ? {24'h0, m_q[0]} : 32'hDEAD_BEEF);
            end
            default: ;
         endcase
         if (r0) begin
            m_q.push_back(s0_data);
            m_rr = 1'b0;
         end else if (r1) begin
            m_q.push_back(s1_data);
            m_rr = 1'b1;
         end
         if (m_act == A_WRITE && m_q.size() > 0) void'(m_q.pop_front());
         case (m_act)
            A_BAUD:  m_act = A_CTRL;
            A_CTRL:  m_act = A_IDLE;
            A_IDLE:  m_act = (en && n > 0) ? A_POLL : A_IDLE;
            A_POLL:  m_act = !en ? A_IDLE : (data_i[0] ? A_POLL : A_WRITE);
            default: m_act = (en && m_q.size() > 0) ? A_POLL : A_IDLE;
         endcase
      end
   end

   task automatic wait_idle(input string nm);
      int k = 0;
      @(negedge clk);
      while (busy !== 1'b0 && k < 600) begin
         @(negedge clk);
         k++;
      end
      chk(nm, busy, 0);
   endtask

   task automatic send0(input int cnt, input logic [7:0] first);
      int k = 0, got = 0;
      @(posedge clk);
      #1 s0_valid = 1'b1;
      s0_data = first;
      while (got < cnt && k < 400) begin
         bit acc;
         @(negedge clk);
         acc = s0_ready;
         k++;
         @(posedge clk);
         #1;
         if (acc) begin
            got++;
            s0_data = s0_data + 8'd1;
         end
         s0_valid = got < cnt;
      end
      s0_valid = 1'b0;
      chk("send0_count", got, cnt);
   endtask

   initial begin
      int k, c0, c1;
      bit a0, a1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      en = 1'b1;
      @(negedge clk);
      chk("init_baud_addr", addr_o, 32'h3000_0008);
      chk("init_baud_data", data_o, 32'h0000_01B8);
      chk("init_baud_we", we_o, 1);
      @(negedge clk);
      chk("init_ctrl_addr", addr_o, 32'h3000_0000);
      chk("init_ctrl_data", data_o, 32'h0000_0001);
      @(negedge clk);
      chk("init_done_req", req_o, 0);
      @(posedge clk);
      #1 s0_valid = 1'b1;
      s0_data = 8'h55;
      @(posedge clk);
      #1 s0_valid = 1'b0;
      @(negedge clk);
      chk("sb_idle_req", req_o, 0);
      chk("sb_level", level, 1);
      @(negedge clk);
      chk("sb_poll_addr", addr_o, 32'h3000_0004);
      chk("sb_poll_we", we_o, 0);
      @(negedge clk);
      chk("sb_write_addr", addr_o, 32'h3000_000C);
      chk("sb_write_data", data_o, 32'h0000_0055);
      chk("sb_write_we", we_o, 1);
      wait_idle("sb_busy_drop");
      // Reset in the middle of a stalled stream.
      @(posedge clk);
      #1 force_busy = 1'b1;
      send0(3, 8'h10);
      @(negedge clk);
      chk("mr_level_before", level, 3);
      @(posedge clk);
      #1 rst = 1'b0;
      force_busy = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("mr_level_rst", level, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("mr_baud_addr", addr_o, 32'h3000_0008);
      chk("mr_baud_data", data_o, 32'h0000_01B8);
      @(negedge clk);
      chk("mr_ctrl_addr", addr_o, 32'h3000_0000);
      // Contention, arbiter fresh from reset.
      wr_log.delete();
      @(posedge clk);
      #1 s0_valid = 1'b1;
      s1_valid = 1'b1;
      s0_data = 8'hA0;
      s1_data = 8'hB0;
      c0 = 0;
      c1 = 0;
      k = 0;
      while ((c0 < 3 || c1 < 3) && k < 200) begin
         @(negedge clk);
         a0 = s0_valid && s0_ready;
         a1 = s1_valid && s1_ready;
         k++;
         @(posedge clk);
         #1;
         if (a0) begin c0++; s0_data = s0_data + 8'd1; end
         if (a1) begin c1++; s1_data = s1_data + 8'd1; end
         s0_valid = c0 < 3;
         s1_valid = c1 < 3;
      end
      k = 0;
      while (wr_log.size() < 6 && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("ct_count", wr_log.size(), 6);
      for (int i = 0; i < 6; i++) chk("ct_order", wr_log[i], ct_exp[i]);
      wait_idle("ct_drain");
      // Full FIFO with the UART held busy.
      @(posedge clk);
      #1 force_busy = 1'b1;
      send0(16, 8'h40);
      @(posedge clk);
      #1 s0_valid = 1'b1;
      s0_data = 8'h50;
      @(negedge clk);
      chk("full_level", level, 16);
      chk("full_ready", s0_ready, 0);
      @(posedge clk);
      #1 force_busy = 1'b0;
      k = 0;
      a0 = 1'b0;
      while (!a0 && k < 50) begin
         @(negedge clk);
         a0 = s0_ready;
         k++;
         @(posedge clk);
         #1;
      end
      s0_valid = 1'b0;
      chk("full_17th_accept", a0, 1);
      wait_idle("full_drain");
      // Sustained drain with a short frame.
      @(posedge clk);
      #1 force_busy = 1'b1;
      frame = 4;
      send0(8, 8'h60);
      wr_log.delete();
      @(posedge clk);
      #1 force_busy = 1'b0;
      k = 0;
      while (wr_log.size() < 8 && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk("sus_count", wr_log.size(), 8);
      wait_idle("sus_drain");
      // en dropped while polling.
      @(posedge clk);
      #1 force_busy = 1'b1;
      send0(1, 8'h3C);
      k = 0;
      while (!(req_o && !we_o) && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("en_poll_seen", req_o && !we_o, 1);
      @(posedge clk);
      #1 en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("en_off_req", req_o, 0);
      chk("en_off_level", level, 1);
      @(posedge clk);
      #1 en = 1'b1;
      force_busy = 1'b0;
      wait_idle("en_drain");
      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1 s0_valid = $urandom_range(0, 99) < 40;
         s1_valid = $urandom_range(0, 99) < 30;
         s0_data = 8'($urandom);
         s1_data = 8'($urandom);
         if ($urandom_range(0, 99) < 3) en = ~en;
         if ($urandom_range(0, 199) == 0) frame = $urandom_range(0, 8);
         force_busy = $urandom_range(0, 99) < 4;
         rst = $urandom_range(0, 999) != 0;
      end
      @(posedge clk);
      #1 s0_valid = 1'b0;
      s1_valid = 1'b0;
      en = 1'b1;
      rst = 1'b1;
      force_busy = 1'b0;
      wait_idle("final_drain");
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
